pipeline_controller: RTL

PIPELINE_CONTROLLER -- requirements
Module: pipeline_controller

---
 rtl/pipeline_controller.sv | 119 +++++++++++
 1 files changed

// File: rtl/pipeline_controller.sv
// Pipeline hazard/redirect controller: RUN/STALL/FLUSH/HALTED FSM with registered outputs.
// Optional stall performance counter enabled by defining PIPE_CTRL_PERF_EN.
`ifndef ADDRESS_SIZE
`define ADDRESS_SIZE 32
`endif

module pipeline_controller #(
   parameter int unsigned FLUSH_LEN = 2
) (
   input  logic                     clock,
   input  logic                     reset,
   input  logic                     load_hazard,
   input  logic                     mc_busy,
   input  logic                     branch_taken,
   input  logic [`ADDRESS_SIZE-1:0] branch_target,
   input  logic                     halt_detected,
   input  logic                     resume,
   output logic                     stall,
   output logic                     jump,
   output logic [`ADDRESS_SIZE-1:0] jump_pc,
   output logic                     flush,
   output logic                     halt,
   output logic [1:0]               state,
   output logic [15:0]              stall_count
);

   typedef enum logic [1:0] {
      ST_RUN    = 2'd0,
      ST_STALL  = 2'd1,
      ST_FLUSH  = 2'd2,
      ST_HALTED = 2'd3
   } state_t;

   // Counter holds the number of flush cycles still to follow the current one.
   localparam logic [2:0] FLUSH_LOAD = 3'(FLUSH_LEN - 1);

   state_t                     cur;
   state_t                     nxt;
   logic [2:0]                 flush_cnt;
   logic [2:0]                 flush_cnt_nxt;
   logic                       jump_nxt;
   logic [`ADDRESS_SIZE-1:0]   pc_nxt;
   logic                       busy;

   assign busy  = load_hazard | mc_busy;
   assign state = cur;

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         cur       <= ST_RUN;
         flush_cnt <= '0;
         jump      <= 1'b0;
         jump_pc   <= '0;
         stall     <= 1'b0;
         flush     <= 1'b0;
         halt      <= 1'b0;
      end else begin
         cur       <= nxt;
         flush_cnt <= flush_cnt_nxt;
         jump      <= jump_nxt;
         jump_pc   <= pc_nxt;
         stall     <= (nxt == ST_STALL);
         flush     <= (nxt == ST_FLUSH);
         halt      <= (nxt == ST_HALTED);
      end
   end

   always_comb begin
      nxt           = cur;
      flush_cnt_nxt = flush_cnt;
      jump_nxt      = 1'b0;
      pc_nxt        = jump_pc;
      unique case (cur)
         ST_RUN, ST_STALL: begin
            if (halt_detected) begin
               nxt = ST_HALTED;
            end else if (branch_taken) begin
               nxt           = ST_FLUSH;
               flush_cnt_nxt = FLUSH_LOAD;
               jump_nxt      = 1'b1;
               pc_nxt        = branch_target;
            end else if (busy) begin
               nxt = ST_STALL;
            end else begin
               nxt = ST_RUN;
            end
         end
         ST_FLUSH: begin
            // Branch and halt here come from squashed instructions and are ignored.
            if (flush_cnt == '0) begin
               nxt = busy ? ST_STALL : ST_RUN;
            end else begin
               flush_cnt_nxt = flush_cnt - 3'd1;
            end
         end
         ST_HALTED: begin
            if (resume) nxt = ST_RUN;
         end
         default: nxt = ST_RUN;
      endcase
   end

`ifdef PIPE_CTRL_PERF_EN
   logic [15:0] stall_cnt_q;

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         stall_cnt_q <= '0;
      end else if (stall && (stall_cnt_q != '1)) begin
         stall_cnt_q <= stall_cnt_q + 16'd1;
      end
   end

   assign stall_count = stall_cnt_q;
`else
   assign stall_count = '0;
`endif

endmodule
